// File: rtl/mc_controller.sv
// Multicycle control FSM for the 32-bit RISC core: sequences fetch/decode/execute/memory/writeback,
// drives datapath enables and aluop, flags undefined opcodes and counts retired instructions.
module mc_controller #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [3:0]           op_i,
    input  logic                 mem_ready_i,
    output logic                 pcwrite_o,
    output logic                 branch_o,
    output logic                 iord_o,
    output logic                 memwrite_o,
    output logic                 irwrite_o,
    output logic                 regwrite_o,
    output logic                 regdst_o,
    output logic                 memtoreg_o,
    output logic                 alusrca_o,
    output logic [1:0]           alusrcb_o,
    output logic [1:0]           pcsrc_o,
    output logic [1:0]           aluop_o,
    output logic                 illegal_op_o,
    output logic                 instr_done_o,
    output logic [3:0]           state_o,
    output logic [CNT_WIDTH-1:0] instret_o
);

    // state  | meaning
    // FETCH  | read instruction at PC, PC+4, wait for mem_ready
    // DECODE | register read, branch target into ALUOut, dispatch on op
    // MEMADR | effective address for lw/sw
    // MEMRD  | load data read, wait for mem_ready
    // MEMWB  | load data to rt
    // MEMWR  | store, strobe held until mem_ready
    // EXEC   | R-type ALU operation
    // ALUWB  | R-type result to rd
    // BRANCH | beq compare, conditional PC write
    // IMMEX  | addi/slti ALU operation with sign-extended immediate
    // IMMWB  | immediate result to rt
    // JUMP   | PC <= jump target
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_IMMEX  = 4'd9,
        S_IMMWB  = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [3:0] OP_R    = 4'b0000;
    localparam logic [3:0] OP_ADDI = 4'b0001;
    localparam logic [3:0] OP_SLTI = 4'b0010;
    localparam logic [3:0] OP_LW   = 4'b0011;
    localparam logic [3:0] OP_SW   = 4'b0100;
    localparam logic [3:0] OP_BEQ  = 4'b0101;
    localparam logic [3:0] OP_J    = 4'b0110;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] instret_q, instret_d;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pcwrite_o    = 1'b0;
        branch_o     = 1'b0;
        iord_o       = 1'b0;
        memwrite_o   = 1'b0;
        irwrite_o    = 1'b0;
        regwrite_o   = 1'b0;
        regdst_o     = 1'b0;
        memtoreg_o   = 1'b0;
        alusrca_o    = 1'b0;
        alusrcb_o    = 2'b00;
        pcsrc_o      = 2'b00;
        aluop_o      = 2'b00;
        illegal_op_o = 1'b0;
        instr_done_o = 1'b0;
        state_o      = state_q;
        instret_o    = instret_q;

        case (state_q)
            S_FETCH: begin
                alusrcb_o = 2'b01;
                aluop_o   = 2'b11;
                irwrite_o = mem_ready_i;
                pcwrite_o = mem_ready_i;
                if (mem_ready_i) state_d = S_DECODE;
            end
            S_DECODE: begin
                alusrcb_o = 2'b11;
                aluop_o   = 2'b11;
                case (op_i)
                    OP_LW, OP_SW:     state_d = S_MEMADR;
                    OP_R:             state_d = S_EXEC;
                    OP_ADDI, OP_SLTI: state_d = S_IMMEX;
                    OP_BEQ:           state_d = S_BRANCH;
                    OP_J:             state_d = S_JUMP;
                    default: begin
                        illegal_op_o = 1'b1;
                        state_d      = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca_o = 1'b1;
                alusrcb_o = 2'b10;
                aluop_o   = 2'b11;
                state_d   = (op_i == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                iord_o = 1'b1;
                if (mem_ready_i) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                memtoreg_o   = 1'b1;
                regwrite_o   = 1'b1;
                instr_done_o = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWR: begin
                iord_o       = 1'b1;
                memwrite_o   = 1'b1;
                instr_done_o = mem_ready_i;
                if (mem_ready_i) state_d = S_FETCH;
            end
            S_EXEC: begin
                alusrca_o = 1'b1;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                regdst_o     = 1'b1;
                regwrite_o   = 1'b1;
                instr_done_o = 1'b1;
                state_d      = S_FETCH;
            end
            S_BRANCH: begin
                alusrca_o    = 1'b1;
                aluop_o      = 2'b10;
                branch_o     = 1'b1;
                pcsrc_o      = 2'b01;
                instr_done_o = 1'b1;
                state_d      = S_FETCH;
            end
            S_IMMEX: begin
                alusrca_o = 1'b1;
                alusrcb_o = 2'b10;
                aluop_o   = (op_i == OP_SLTI) ? 2'b01 : 2'b11;
                state_d   = S_IMMWB;
            end
            S_IMMWB: begin
                regwrite_o   = 1'b1;
                instr_done_o = 1'b1;
                state_d      = S_FETCH;
            end
            S_JUMP: begin
                pcsrc_o      = 2'b10;
                pcwrite_o    = 1'b1;
                instr_done_o = 1'b1;
                state_d      = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        // Reset masks every output so no strobe or pulse escapes during an abandoned instruction.
        if (reset_i) begin
            pcwrite_o    = 1'b0;
            branch_o     = 1'b0;
            iord_o       = 1'b0;
            memwrite_o   = 1'b0;
            irwrite_o    = 1'b0;
            regwrite_o   = 1'b0;
            regdst_o     = 1'b0;
            memtoreg_o   = 1'b0;
            alusrca_o    = 1'b0;
            alusrcb_o    = 2'b00;
            pcsrc_o      = 2'b00;
            aluop_o      = 2'b00;
            illegal_op_o = 1'b0;
            instr_done_o = 1'b0;
            state_o      = 4'd0;
            instret_o    = '0;
        end

        instret_d = instret_q + {{(CNT_WIDTH-1){1'b0}}, instr_done_o};
    end

endmodule
